// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multicycle program-counter sequencer. It is the only writer of the PC
//   register's write port. Each instruction is sequenced through FETCH,
//   WAIT (instruction memory), EXEC (execute stage) and UPDATE (PC write).
//   The next PC is either the sequential PC+4 or a branch target. A misaligned
//   next PC is redirected to TRAP_VECTOR, or the sequencer halts if
//   TRAP_VECTOR is itself misaligned.
//
// Parameters
//   INITIAL_PC   PC written in INIT, the first cycle after reset is released
//   TRAP_VECTOR  PC written when a misaligned next PC is detected
//
// Ports
//   clock                      rising-edge clock
//   reset                      synchronous, active-low reset
//   pcOfInstruction            current PC from the PC register
//   programCounterMisaligned   misalignment flag from the PC register
//   programCounterInput        next-PC value to the PC register
//   programCounterWriteEnable  PC register write strobe
//   stall                      holds the sequencer in FETCH
//   fetchRequest/fetchAddress  instruction-fetch request and address
//   fetchReady/fetchInstruction memory acknowledge and fetched word
//   instructionOut/instructionValid  latched instruction for execute
//   executeDone                execute stage finished the current instruction
//   branchTaken/branchTarget   next-PC selection, sampled with executeDone
//   trapTaken                  one-cycle pulse when a trap redirect is written
//   faultPC                    last misaligned next PC that caused a trap
//   trapCount                  saturating trap counter
//   halted                     sequencer stopped; only reset exits
//   debugState                 current FSM state, for observation only
//
// Handshakes: fetchRequest is held high from the cycle after FETCH up to and
// including the cycle in which fetchReady is seen; the word on
// fetchInstruction is taken in that cycle. instructionValid is held high until
// executeDone is seen, and branchTaken/branchTarget are taken in that same
// cycle. Each request/valid drops in the cycle after its acknowledge.
//
// All outputs are registers, so they depend on state and stored values only.

module pc_sequencer #(
  parameter logic [31:0] INITIAL_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcOfInstruction,
  input  logic        programCounterMisaligned,
  output logic [31:0] programCounterInput,
  output logic        programCounterWriteEnable,
  input  logic        stall,
  output logic        fetchRequest,
  output logic [31:0] fetchAddress,
  input  logic        fetchReady,
  input  logic [31:0] fetchInstruction,
  output logic [31:0] instructionOut,
  output logic        instructionValid,
  input  logic        executeDone,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        trapTaken,
  output logic [31:0] faultPC,
  output logic [7:0]  trapCount,
  output logic        halted,
  output logic [2:0]  debugState
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    EXEC   = 3'd3,
    UPDATE = 3'd4,
    HALT   = 3'd5
  } stateT;

  // A misaligned trap vector cannot be written, so a trap turns into a halt.
  localparam logic trapHalts = (TRAP_VECTOR[1:0] != 2'b00);

  stateT       state;
  logic        resetHold;   // set while reset is applied; the INIT write waits for its release
  logic [31:0] capturedPc;
  logic [31:0] nextPc;
  logic [31:0] candidatePc;

  assign fetchAddress = capturedPc;
  assign debugState   = state;

  // Next-PC selection evaluated in EXEC; addition wraps modulo 2^32.
  always_comb begin
    candidatePc = capturedPc + 32'd4;
    if (branchTaken) candidatePc = branchTarget;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                     <= INIT;
      resetHold                 <= 1'b1;
      capturedPc                <= 32'h0;
      nextPc                    <= 32'h0;
      instructionOut            <= 32'h0;
      faultPC                   <= 32'h0;
      trapCount                 <= 8'h0;
      programCounterInput       <= 32'h0;
      programCounterWriteEnable <= 1'b0;
      fetchRequest              <= 1'b0;
      instructionValid          <= 1'b0;
      trapTaken                 <= 1'b0;
      halted                    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (resetHold) begin
            // First cycle out of reset: present the initial PC write.
            resetHold                 <= 1'b0;
            programCounterWriteEnable <= 1'b1;
            programCounterInput       <= INITIAL_PC;
          end else begin
            programCounterWriteEnable <= 1'b0;
            state                     <= FETCH;
          end
        end

        FETCH: begin
          if (programCounterMisaligned) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (!stall) begin
            capturedPc   <= pcOfInstruction;
            fetchRequest <= 1'b1;
            state        <= WAIT;
          end
        end

        WAIT: begin
          if (fetchReady) begin
            instructionOut   <= fetchInstruction;
            fetchRequest     <= 1'b0;
            instructionValid <= 1'b1;
            state            <= EXEC;
          end
        end

        EXEC: begin
          if (executeDone) begin
            instructionValid <= 1'b0;
            nextPc           <= candidatePc;
            state            <= UPDATE;
            // UPDATE outputs are prepared here so they are registered.
            if (candidatePc[1:0] == 2'b00) begin
              programCounterWriteEnable <= 1'b1;
              programCounterInput       <= candidatePc;
            end else if (!trapHalts) begin
              programCounterWriteEnable <= 1'b1;
              programCounterInput       <= TRAP_VECTOR;
              trapTaken                 <= 1'b1;
            end
          end
        end

        UPDATE: begin
          programCounterWriteEnable <= 1'b0;
          trapTaken                 <= 1'b0;
          if (nextPc[1:0] != 2'b00) begin
            faultPC <= nextPc;
            if (trapCount != 8'hFF) trapCount <= trapCount + 8'd1;
            if (trapHalts) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              state <= FETCH;
            end
          end else begin
            state <= FETCH;
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          // Unused encodings stop the sequencer rather than run from garbage.
          halted <= 1'b1;
          state  <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Drives two pc_sequencer instances from the same stimulus: one with the
//   default aligned trap vector, one with a misaligned trap vector (which must
//   halt on its first trap). Each DUT has its own PC register model. Expected
//   outputs are generated per instruction as a cycle-by-cycle list from the
//   instruction's stall/latency/branch parameters, and a compare process checks
//   the DUTs against that list every cycle.

module tb_pc_sequencer;

  localparam logic [31:0] INITIAL_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_A     = 32'h0000_0004;
  localparam logic [31:0] TRAP_B     = 32'h0000_0002;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // ---------------- shared inputs ----------------
  logic        stall, fetchReady, executeDone, branchTaken;
  logic [31:0] fetchInstruction, branchTarget;

  // ---------------- DUT A (aligned trap vector) ----------------
  logic [31:0] pcIn1, fetchAddr1, instrOut1, fault1;
  logic        pcWe1, fetchReq1, valid1, trap1, halted1;
  logic [7:0]  count1;
  logic [2:0]  dbg1;
  logic [31:0] pcReg1 = 32'h0;
  logic        mis1;
  assign mis1 = (pcReg1[1:0] != 2'b00);
  always @(posedge clock) if (pcWe1 === 1'b1) pcReg1 <= pcIn1;

  pc_sequencer #(.INITIAL_PC(INITIAL_PC), .TRAP_VECTOR(TRAP_A)) dutA (
    .clock(clock), .reset(reset),
    .pcOfInstruction(pcReg1), .programCounterMisaligned(mis1),
    .programCounterInput(pcIn1), .programCounterWriteEnable(pcWe1),
    .stall(stall), .fetchRequest(fetchReq1), .fetchAddress(fetchAddr1),
    .fetchReady(fetchReady), .fetchInstruction(fetchInstruction),
    .instructionOut(instrOut1), .instructionValid(valid1),
    .executeDone(executeDone), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .trapTaken(trap1), .faultPC(fault1), .trapCount(count1), .halted(halted1),
    .debugState(dbg1)
  );

  // ---------------- DUT B (misaligned trap vector) ----------------
  logic [31:0] pcIn2, fetchAddr2, instrOut2, fault2;
  logic        pcWe2, fetchReq2, valid2, trap2, halted2;
  logic [7:0]  count2;
  logic [2:0]  dbg2;
  logic [31:0] pcReg2 = 32'h0;
  logic        mis2;
  assign mis2 = (pcReg2[1:0] != 2'b00);
  always @(posedge clock) if (pcWe2 === 1'b1) pcReg2 <= pcIn2;

  pc_sequencer #(.INITIAL_PC(INITIAL_PC), .TRAP_VECTOR(TRAP_B)) dutB (
    .clock(clock), .reset(reset),
    .pcOfInstruction(pcReg2), .programCounterMisaligned(mis2),
    .programCounterInput(pcIn2), .programCounterWriteEnable(pcWe2),
    .stall(stall), .fetchRequest(fetchReq2), .fetchAddress(fetchAddr2),
    .fetchReady(fetchReady), .fetchInstruction(fetchInstruction),
    .instructionOut(instrOut2), .instructionValid(valid2),
    .executeDone(executeDone), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .trapTaken(trap2), .faultPC(fault2), .trapCount(count2), .halted(halted2),
    .debugState(dbg2)
  );

  // ---------------- scoreboard ----------------
  // h2: 0 = DUT B expected identical to DUT A, 1 = DUT B in its trap UPDATE
  // cycle (no write, no pulse), 2 = DUT B halted.
  typedef struct packed {
    logic        check;
    logic        full;
    logic        pcWe;
    logic [31:0] pcIn;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        valid;
    logic [31:0] instr;
    logic        trap;
    logic [31:0] fault;
    logic [7:0]  count;
    logic        halted;
    logic [1:0]  h2;
  } expT;

  expT exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  reqCycles   = 0;

  // model state
  logic [31:0] mPc    = 32'h0;
  logic [31:0] mFault = 32'h0;
  logic [7:0]  mCount = 8'h0;
  logic        mH2    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, want);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    chk(name, act, want);
  endtask

  task automatic checkDut(input string tag, input logic we, input logic [31:0] pin_,
                          input logic req, input logic [31:0] addr, input logic v,
                          input logic [31:0] ins, input logic tr, input logic [31:0] flt,
                          input logic [7:0] cnt, input logic h, input expT e);
    chk({tag, ".pcWe"}, 32'(we), 32'(e.pcWe));
    if (e.full || e.pcWe) chk({tag, ".pcIn"}, pin_, e.pcIn);
    chk({tag, ".fetchRequest"}, 32'(req), 32'(e.fetchReq));
    if (e.full || e.fetchReq) chk({tag, ".fetchAddress"}, addr, e.fetchAddr);
    chk({tag, ".instructionValid"}, 32'(v), 32'(e.valid));
    if (e.full || e.valid) chk({tag, ".instructionOut"}, ins, e.instr);
    chk({tag, ".trapTaken"}, 32'(tr), 32'(e.trap));
    chk({tag, ".faultPC"}, flt, e.fault);
    chk({tag, ".trapCount"}, 32'(cnt), 32'(e.count));
    chk({tag, ".halted"}, 32'(h), 32'(e.halted));
  endtask

  expT ce;
  always @(negedge clock) begin
    if (fetchReq1 === 1'b1) reqCycles++;
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      if (ce.check) begin
        vectors++;
        checkDut("A", pcWe1, pcIn1, fetchReq1, fetchAddr1, valid1, instrOut1,
                 trap1, fault1, count1, halted1, ce);
        if (ce.h2 == 2'd0) begin
          checkDut("B", pcWe2, pcIn2, fetchReq2, fetchAddr2, valid2, instrOut2,
                   trap2, fault2, count2, halted2, ce);
        end else begin
          chk("B.pcWe", 32'(pcWe2), 32'h0);
          chk("B.trapTaken", 32'(trap2), 32'h0);
          chk("B.fetchRequest", 32'(fetchReq2), 32'h0);
          chk("B.instructionValid", 32'(valid2), 32'h0);
          chk("B.halted", 32'(halted2), (ce.h2 == 2'd2) ? 32'h1 : 32'h0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input expT e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  function automatic expT idle();
    expT e;
    e       = '0;
    e.check = 1'b1;
    e.fault = mFault;
    e.count = mCount;
    e.h2    = mH2 ? 2'd2 : 2'd0;
    return e;
  endfunction

  task automatic randomizeAll();
    stall            = 1'($urandom);
    fetchReady       = 1'($urandom);
    executeDone      = 1'($urandom);
    branchTaken      = 1'($urandom);
    branchTarget     = $urandom;
    fetchInstruction = $urandom;
  endtask

  task automatic doReset(input int n);
    expT e;
    randomizeAll(); reset = 1'b0;
    e = '0; step(e);                       // outputs still show the prior state
    mPc = INITIAL_PC; mFault = 32'h0; mCount = 8'h0; mH2 = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      randomizeAll(); reset = 1'b0;
      e = '0; e.check = 1'b1; e.full = 1'b1; step(e);
    end
    randomizeAll(); reset = 1'b1;
    e = '0; e.check = 1'b1; e.full = 1'b1; step(e);
    randomizeAll();
    e = idle(); e.pcWe = 1'b1; e.pcIn = INITIAL_PC; step(e);  // INIT
  endtask

  // s: stall cycles, r: extra WAIT cycles, x: extra EXEC cycles
  // abortAt: 0 none, 1 reset while in WAIT, 2 reset while in EXEC
  task automatic runInstr(input int s, input int r, input int x, input logic b,
                          input logic [31:0] t, input int abortAt);
    logic [31:0] w, nxt;
    expT e;
    w = $urandom;
    for (int i = 0; i <= s; i++) begin
      randomizeAll(); stall = (i < s);
      e = idle(); step(e);
    end
    for (int i = 0; i <= r; i++) begin
      randomizeAll(); fetchReady = (i == r) && (abortAt != 1);
      if (fetchReady) fetchInstruction = w;
      e = idle(); e.fetchReq = 1'b1; e.fetchAddr = mPc; step(e);
    end
    if (abortAt == 1) begin doReset(2); return; end
    for (int i = 0; i <= x; i++) begin
      randomizeAll(); executeDone = (i == x) && (abortAt != 2);
      if (executeDone) begin branchTaken = b; branchTarget = t; end
      e = idle(); e.valid = 1'b1; e.instr = w; step(e);
    end
    if (abortAt == 2) begin doReset(2); return; end
    nxt = b ? t : mPc + 32'd4;
    randomizeAll();
    e = idle(); e.pcWe = 1'b1;
    if (nxt[1:0] == 2'b00) begin
      e.pcIn = nxt; step(e);
      mPc = nxt;
    end else begin
      e.pcIn = TRAP_A; e.trap = 1'b1;
      if (!mH2) e.h2 = 2'd1;
      step(e);
      mFault = nxt;
      mCount = (mCount == 8'd255) ? 8'd255 : mCount + 8'd1;
      mPc    = TRAP_A;
      mH2    = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t;
    reset = 1'b0;
    randomizeAll();
    @(posedge clock); #1;

    doReset(3);
    for (int k = 0; k < 4; k++) runInstr(0, 0, 0, 1'b0, 32'h0, 0);   // 0,4,8,C
    pin("model.pc_after_seq", mPc, 32'h10);
    pin("A.pc_reg_after_seq", pcReg1, 32'h10);
    runInstr(0, 0, 0, 1'b1, 32'h100, 0);                               // branch at 0x10
    pin("model.pc_after_branch", mPc, 32'h100);
    runInstr(1, 1, 1, 1'b1, 32'h20, 0);
    runInstr(0, 0, 0, 1'b1, 32'h102, 0);                               // misaligned at 0x20
    pin("model.faultPC", mFault, 32'h102);
    pin("A.faultPC_literal", fault1, 32'h102);
    pin("A.trapCount_literal", 32'(count1), 32'h1);
    pin("model.pc_after_trap", mPc, 32'h4);
    pin("B.halted_literal", 32'(halted2), 32'h1);

    reqCycles = 0;
    runInstr(2, 3, 0, 1'b0, 32'h0, 0);                                 // 9-cycle instruction
    pin("fetchRequest_cycles", 32'(reqCycles), 32'h4);

    runInstr(0, 0, 0, 1'b1, 32'hFFFF_FFFC, 0);
    runInstr(0, 1, 0, 1'b0, 32'h0, 0);                                 // wraps to 0
    pin("model.pc_wrap", mPc, 32'h0);

    for (int k = 0; k < 200; k++) begin
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      runInstr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 2) == 0), t, 0);
    end

    runInstr(1, 2, 0, 1'b0, 32'h0, 1);                                 // reset mid-WAIT
    pin("model.pc_after_abort", mPc, INITIAL_PC);
    runInstr(0, 0, 0, 1'b0, 32'h0, 0);
    runInstr(0, 0, 2, 1'b0, 32'h0, 2);                                 // reset mid-EXEC
    runInstr(0, 0, 0, 1'b0, 32'h0, 0);

    for (int k = 0; k < 256; k++) begin
      t = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      runInstr(0, 0, 0, 1'b1, t, 0);
    end
    pin("model.trapCount_sat", 32'(mCount), 32'd255);
    pin("A.trapCount_sat", 32'(count1), 32'd255);
    runInstr(0, 0, 0, 1'b1, 32'h13, 0);
    pin("A.trapCount_no_wrap", 32'(count1), 32'd255);

    for (int k = 0; k < 5; k++) runInstr($urandom_range(0, 1), $urandom_range(0, 2), 0, 1'b0, 32'h0, 0);
    pin("B.halted_end", 32'(halted2), 32'h1);
    pin("B.pcWe_end", 32'(pcWe2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
